// File: rtl/nebula_pkg.sv
// Shared NoC types: flit format plus traffic-generator pattern and state enums.
package nebula_pkg;

    localparam int FLIT_DATA_W = 32;
    localparam int COORD_W     = 4;
    localparam int SEQ_W       = 8;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1

    typedef enum logic [1:0] {
        PACKET_DATA = 2'd0,
        PACKET_REQ  = 2'd1,
        PACKET_RESP = 2'd2,
        PACKET_CTRL = 2'd3
    } packet_type_t;

    typedef struct packed {
        logic                   valid;
        packet_type_t           packet_type;
        logic [COORD_W-1:0]     src_x;
        logic [COORD_W-1:0]     src_y;
        logic [COORD_W-1:0]     dst_x;
        logic [COORD_W-1:0]     dst_y;
        logic [SEQ_W-1:0]       sequence_num;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        UNIFORM_RANDOM   = 2'd0,
        NEAREST_NEIGHBOR = 2'd1,
        HOTSPOT          = 2'd2,
        TRANSPOSE        = 2'd3
    } tg_pattern_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tg_state_t;

    function automatic logic [COORD_W-1:0] coord_mod(input int v, input int n);
        return COORD_W'(v % n);
    endfunction

endpackage

// File: rtl/nebula_lfsr.sv
// 16-bit maximal-length Galois LFSR; a zero seed is replaced by 0x0001.
module nebula_lfsr
    import nebula_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 16'h0001;
        end else if (load) begin
            value <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (en) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/nebula_traffic_gen.sv
// Synthetic NoC traffic generator: injects flits by pattern, counts responses.
// Define NEBULA_TG_LATENCY_EN to timestamp flits and track response latency.
module nebula_traffic_gen
    import nebula_pkg::*;
#(
    parameter int MY_X          = 0,
    parameter int MY_Y          = 0,
    parameter int MESH_SIZE_X   = 4,
    parameter int MESH_SIZE_Y   = 4,
    parameter int CNT_W         = 16,
    parameter int TS_W          = 16,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  tg_pattern_t       pattern,
    input  logic [3:0]        inj_rate,
    input  logic [CNT_W-1:0]  num_packets,
    input  logic [3:0]        hotspot_x,
    input  logic [3:0]        hotspot_y,
    input  logic [15:0]       seed,
    output flit_t             req_data,
    output logic              req_valid,
    input  logic              req_ready,
    input  flit_t             resp_data,
    input  logic              resp_valid,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  pkts_sent,
    output logic [CNT_W-1:0]  pkts_received,
    output logic [TS_W-1:0]   max_latency,
    output logic [31:0]       lat_sum
);

    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

    tg_state_t              state_q, state_d;
    tg_pattern_t            pattern_q;
    logic [3:0]             rate_q, hs_x_q, hs_y_q;
    logic [CNT_W-1:0]       num_q;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [15:0]            lfsr_val;
    logic                   accept_start, send_hs, recv_hs, form_flit;
    logic                   drained, drain_expired;
    logic [CNT_W-1:0]       sent_inc, recv_inc, sent_next;
    logic [COORD_W-1:0]     dst_x, dst_y;
    logic [FLIT_DATA_W-1:0] flit_payload;
    logic                   unused_bits;

    assign accept_start  = start && (state_q == IDLE || state_q == DONE);
    assign send_hs       = req_valid && req_ready;
    assign recv_hs       = resp_valid && resp_ready && (state_q == RUN || state_q == DRAIN);
    assign sent_inc      = (&pkts_sent) ? pkts_sent : pkts_sent + 1'b1;
    assign recv_inc      = (&pkts_received) ? pkts_received : pkts_received + 1'b1;
    assign sent_next     = send_hs ? sent_inc : pkts_sent;
    assign drained       = pkts_received >= pkts_sent;
    assign drain_expired = drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1);

    // A new flit may replace the current one in the same cycle it is accepted.
    assign form_flit = (state_q == RUN) && (!req_valid || req_ready) &&
                       (sent_next < num_q) && (lfsr_val[3:0] <= rate_q);

    assign resp_ready = rst_n;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    nebula_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_start),
        .seed  (seed),
        .en    (state_q == RUN),
        .value (lfsr_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = (num_packets == '0) ? DONE : RUN;
            RUN:        if (send_hs && sent_inc >= num_q) state_d = DRAIN;
            DRAIN:      if (drained || drain_expired) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        dst_x = hs_x_q;
        dst_y = hs_y_q;
        unique case (pattern_q)
            UNIFORM_RANDOM: begin
                dst_x = coord_mod(int'(lfsr_val[7:4]), MESH_SIZE_X);
                dst_y = coord_mod(int'(lfsr_val[11:8]), MESH_SIZE_Y);
            end
            NEAREST_NEIGHBOR: begin
                dst_x = coord_mod(MY_X + 1, MESH_SIZE_X);
                dst_y = COORD_W'(MY_Y);
            end
            TRANSPOSE: begin
                dst_x = coord_mod(MY_Y, MESH_SIZE_X);
                dst_y = coord_mod(MY_X, MESH_SIZE_Y);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q     <= UNIFORM_RANDOM;
            rate_q        <= '0;
            num_q         <= '0;
            hs_x_q        <= '0;
            hs_y_q        <= '0;
            req_valid     <= 1'b0;
            req_data      <= '0;
            pkts_sent     <= '0;
            pkts_received <= '0;
            drain_cnt     <= '0;
            timeout       <= 1'b0;
        end else if (accept_start) begin
            pattern_q     <= pattern;
            rate_q        <= inj_rate;
            num_q         <= num_packets;
            hs_x_q        <= hotspot_x;
            hs_y_q        <= hotspot_y;
            pkts_sent     <= '0;
            pkts_received <= '0;
            drain_cnt     <= '0;
            timeout       <= 1'b0;
        end else begin
            if (send_hs) pkts_sent <= sent_inc;
            if (recv_hs) pkts_received <= recv_inc;
            if (form_flit) begin
                req_valid             <= 1'b1;
                req_data.valid        <= 1'b1;
                req_data.packet_type  <= PACKET_DATA;
                req_data.src_x        <= COORD_W'(MY_X);
                req_data.src_y        <= COORD_W'(MY_Y);
                req_data.dst_x        <= dst_x;
                req_data.dst_y        <= dst_y;
                req_data.sequence_num <= SEQ_W'(sent_next);
                req_data.data         <= flit_payload;
            end else if (send_hs) begin
                req_valid <= 1'b0;
            end
            if (state_q == DRAIN) begin
                if (drain_cnt != '1) drain_cnt <= drain_cnt + 1'b1;
                if (!drained && drain_expired) timeout <= 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

`ifdef NEBULA_TG_LATENCY_EN
    logic [TS_W-1:0] cycle_q, lat_now;
    logic [32:0]     lat_sum_add;

    // Timestamp is the count of the first cycle the flit is visible on req.
    always_comb begin
        flit_payload             = '0;
        flit_payload[TS_W-1:0]   = cycle_q + 1'b1;
    end

    // Wraps by design: latency is taken modulo 2^TS_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_q <= '0;
        else        cycle_q <= cycle_q + 1'b1;
    end

    assign lat_now     = cycle_q - resp_data.data[TS_W-1:0];
    assign lat_sum_add = {1'b0, lat_sum} + 33'(lat_now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_latency <= '0;
            lat_sum     <= '0;
        end else if (accept_start) begin
            max_latency <= '0;
            lat_sum     <= '0;
        end else if (recv_hs) begin
            if (lat_now > max_latency) max_latency <= lat_now;
            lat_sum <= lat_sum_add[32] ? 32'hFFFF_FFFF : lat_sum_add[31:0];
        end
    end
`else
    always_comb begin
        flit_payload       = '0;
        flit_payload[15:0] = lfsr_val;
    end

    assign max_latency = '0;
    assign lat_sum     = '0;
`endif

    assign unused_bits = ^{resp_data, lfsr_val};

endmodule

// File: tb/tb_nebula_traffic_gen.sv
// Directed bench for nebula_traffic_gen: patterns, back-pressure, drain timeout,
// latency tracking (when NEBULA_TG_LATENCY_EN is defined) and async reset.
module tb_nebula_traffic_gen;
    import nebula_pkg::*;

    localparam int CNT_W = 16;
    localparam int TS_W  = 16;
`ifdef NEBULA_TG_LATENCY_EN
    localparam logic [63:0] EXP_MAXLAT = 64'd7;
    localparam logic [63:0] EXP_LATSUM = 64'd42;
`else
    localparam logic [63:0] EXP_MAXLAT = 64'd0;
    localparam logic [63:0] EXP_LATSUM = 64'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    tg_pattern_t      pattern = NEAREST_NEIGHBOR;
    logic [3:0]       inj_rate = '0;
    logic [CNT_W-1:0] num_packets = '0;
    logic [3:0]       hotspot_x = '0, hotspot_y = '0;
    logic [15:0]      seed = 16'hACE1;
    logic             req_ready = 1'b0;
    flit_t            resp_data = '0;
    logic             resp_valid = 1'b0;
    logic             echo_en = 1'b0;

    flit_t            a_req_data, t_req_data;
    logic             a_req_valid, a_resp_ready, a_busy, a_done, a_timeout;
    logic             t_req_valid, t_resp_ready, t_busy, t_done, t_timeout;
    logic [CNT_W-1:0] a_pkts_sent, a_pkts_received, t_pkts_sent, t_pkts_received;
    logic [TS_W-1:0]  a_max_latency, t_max_latency;
    logic [31:0]      a_lat_sum, t_lat_sum;

    int n_cmp = 0;
    int n_mis = 0;
    int k;
    flit_t held;

    always #5 clk = ~clk;

    nebula_traffic_gen #(.MY_X(3), .MY_Y(1), .DRAIN_TIMEOUT(64)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .inj_rate(inj_rate),
        .num_packets(num_packets), .hotspot_x(hotspot_x), .hotspot_y(hotspot_y), .seed(seed),
        .req_data(a_req_data), .req_valid(a_req_valid), .req_ready(req_ready),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(a_resp_ready),
        .busy(a_busy), .done(a_done), .timeout(a_timeout), .pkts_sent(a_pkts_sent),
        .pkts_received(a_pkts_received), .max_latency(a_max_latency), .lat_sum(a_lat_sum)
    );

    nebula_traffic_gen #(.MY_X(1), .MY_Y(3), .DRAIN_TIMEOUT(64)) u_t (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .inj_rate(inj_rate),
        .num_packets(num_packets), .hotspot_x(hotspot_x), .hotspot_y(hotspot_y), .seed(seed),
        .req_data(t_req_data), .req_valid(t_req_valid), .req_ready(req_ready),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(t_resp_ready),
        .busy(t_busy), .done(t_done), .timeout(t_timeout), .pkts_sent(t_pkts_sent),
        .pkts_received(t_pkts_received), .max_latency(t_max_latency), .lat_sum(t_lat_sum)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Echo each accepted flit of u_a back on resp so it is sampled 7 cycles after its handshake.
    logic  ev [0:7];
    flit_t ed [0:7];
    initial begin
        for (int i = 0; i < 8; i++) begin
            ev[i] = 1'b0;
            ed[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) begin
                ev[i] = ev[i-1];
                ed[i] = ed[i-1];
            end
            ev[0]      = echo_en && a_req_valid && req_ready && rst_n;
            ed[0]      = a_req_data;
            resp_valid = ev[7];
            resp_data  = ed[7];
        end
    end

    initial begin
        tick(3);
        chk("rst_req_valid", 64'(a_req_valid), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_resp_ready", 64'(a_resp_ready), 64'd0);
        chk("rst_pkts_sent", 64'(a_pkts_sent), 64'd0);
        chk("rst_lat_sum", 64'(a_lat_sum), 64'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_resp_ready", 64'(a_resp_ready), 64'd1);
        chk("idle_done", 64'(a_done), 64'd0);

        // Nearest neighbour from (3,1): 5 back-to-back flits, then drain times out.
        pattern = NEAREST_NEIGHBOR; inj_rate = 4'd15; num_packets = 16'd5; req_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("nn_busy", 64'(a_busy), 64'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("nn_valid", 64'(a_req_valid), 64'd1);
            chk("nn_dst", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h01);
            chk("nn_seq", 64'(a_req_data.sequence_num), 64'(i));
            tick();
        end
        chk("nn_pkts_sent", 64'(a_pkts_sent), 64'd5);
        chk("nn_state_drain", 64'(u_a.state_q), 64'(DRAIN));
        chk("nn_valid_off", 64'(a_req_valid), 64'd0);
        k = 0;
        while (!a_done && k < 300) begin tick(); k++; end
        chk("to_cycles", 64'(k), 64'd64);
        chk("to_flag", 64'(a_timeout), 64'd1);
        chk("to_busy", 64'(a_busy), 64'd0);

        // Uniform random with seed 0xACE1: LFSR 0xACE1, 0xE270, 0x7138 -> (2,0),(3,2),(3,1).
        pattern = UNIFORM_RANDOM; num_packets = 16'd3;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("ur_dst0", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h20);
        tick();
        chk("ur_dst1", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h32);
        tick();
        chk("ur_dst2", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h31);
        k = 0;
        while (!a_done && k < 300) begin tick(); k++; end
        chk("ur_done", 64'(a_done), 64'd1);

        // Hotspot (2,2) with responses echoed 7 cycles after each handshake.
        pattern = HOTSPOT; hotspot_x = 4'd2; hotspot_y = 4'd2; num_packets = 16'd6; echo_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("hs_busy", 64'(a_busy), 64'd1);
        chk("hs_sent_clr", 64'(a_pkts_sent), 64'd0);
        chk("hs_timeout_clr", 64'(a_timeout), 64'd0);
        k = 0;
        while (!a_done && k < 300) begin
            if (a_req_valid) chk("hs_dst", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h22);
            tick(); k++;
        end
        chk("hs_done", 64'(a_done), 64'd1);
        chk("hs_timeout", 64'(a_timeout), 64'd0);
        chk("hs_received", 64'(a_pkts_received), 64'd6);
        chk("hs_max_latency", 64'(a_max_latency), EXP_MAXLAT);
        chk("hs_lat_sum", 64'(a_lat_sum), EXP_LATSUM);
        echo_en = 1'b0;
        tick(10);

        // Transpose with a 10-cycle stall after the third handshake.
        pattern = TRANSPOSE; num_packets = 16'd8;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (a_pkts_sent < 16'd3 && k < 50) begin tick(); k++; end
        chk("tp_reach3", 64'(a_pkts_sent), 64'd3);
        req_ready = 1'b0;
        chk("tp_dst_31", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h13);
        chk("tp_dst_13", 64'({t_req_data.dst_x, t_req_data.dst_y}), 64'h31);
        held = a_req_data;
        chk("tp_held_seq", 64'(held.sequence_num), 64'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 64'(a_req_valid), 64'd1);
            chk("stall_data", 64'(a_req_data), 64'(held));
        end
        chk("stall_sent", 64'(a_pkts_sent), 64'd3);

        // Async reset mid-RUN, checked before the next clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req_valid", 64'(a_req_valid), 64'd0);
        chk("mr_req_data", 64'(a_req_data), 64'd0);
        chk("mr_pkts_sent", 64'(a_pkts_sent), 64'd0);
        chk("mr_busy", 64'(a_busy), 64'd0);
        chk("mr_resp_ready", 64'(a_resp_ready), 64'd0);
        tick(2);
        rst_n = 1'b1; req_ready = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("rs_valid", 64'(a_req_valid), 64'd1);
        chk("rs_seq", 64'(a_req_data.sequence_num), 64'd0);
        chk("rs_dst", 64'({a_req_data.dst_x, a_req_data.dst_y}), 64'h13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/nebula_traffic_gen.md
NEBULA_TRAFFIC_GEN -- requirements
Module: nebula_traffic_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MY_X 0 own column; MY_Y 0 own row; MESH_SIZE_X 4 columns; MESH_SIZE_Y 4 rows; CNT_W 16 counter width; TS_W 16 timestamp width (≤ flit data width); DRAIN_TIMEOUT 256 max drain cycles.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk in 1 clock
- rst_n in 1 reset
- start in 1 begin run, pulse
- pattern in 2 tg_pattern_t
- inj_rate in 4 injection threshold
- num_packets in CNT_W packets to send
- hotspot_x, hotspot_y in 4 each hotspot destination
- seed in 16 LFSR seed
- req_data out flit_t injected flit
- req_valid out 1
- req_ready in 1
- resp_data in flit_t ejected flit
- resp_valid in 1
- resp_ready out 1
- busy out 1
- done out 1
- timeout out 1
- pkts_sent, pkts_received out CNT_W each
- max_latency out TS_W
- lat_sum out 32
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low, named rst_n.

Function
REQ-004 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
- IDLE→RUN on start; at that point counters clear, LFSR loads seed (0x0001 if seed==0), and config is latched.
- start with num_packets==0 SHALL go IDLE→DONE directly.
REQ-005 start SHALL be ignored in RUN and DRAIN; in DONE, start SHALL restart as from IDLE.
REQ-006 LFSR SHALL be a 16-bit maximal-length Galois LFSR (taps 16,14,13,11) that advances every cycle in RUN.
REQ-007 In RUN with no pending flit, a flit SHALL be formed when lfsr[3:0] ≤ inj_rate, so 0 gives 1/16 and 15 gives every cycle.
REQ-008 Destination SHALL depend on pattern:
- UNIFORM_RANDOM (0): (lfsr[7:4] mod MESH_SIZE_X, lfsr[11:8] mod MESH_SIZE_Y); self-destination is allowed.
- NEAREST_NEIGHBOR (1): ((MY_X+1) mod MESH_SIZE_X, MY_Y).
- HOTSPOT (2): latched hotspot coordinates.
- TRANSPOSE (3): (MY_Y mod MESH_SIZE_X, MY_X mod MESH_SIZE_Y).
REQ-009 Flit fields SHALL be set as follows:
- packet_type = PACKET_DATA
- src = (MY_X, MY_Y)
- sequence_num = pkts_sent (truncated)
- valid = 1
- data[TS_W-1:0] = free-running cycle counter when latency is enabled; otherwise the LFSR value.
REQ-010 req_valid, once asserted, SHALL stay high with req_data stable until req_valid && req_ready. pkts_sent SHALL increment on that handshake only.
REQ-011 After the handshake that brings pkts_sent to num_packets, the FSM SHALL go to DRAIN.
REQ-012 resp_ready SHALL be 1 whenever rst_n is high. pkts_received SHALL increment on every resp_valid && resp_ready in RUN or DRAIN.
REQ-013 DRAIN→DONE SHALL occur when pkts_received ≥ pkts_sent (timeout=0), or after DRAIN_TIMEOUT cycles in DRAIN (timeout=1).
REQ-014 busy SHALL be 1 in RUN and DRAIN. done SHALL be 1 in DONE.
REQ-015 A simultaneous send handshake and receive in one cycle SHALL update both counters.
REQ-016 All counters SHALL saturate at all-ones rather than wrap.

Reset
REQ-017 Asserting rst_n low SHALL immediately set, at any point including mid-RUN:
- state = IDLE
- req_valid = 0, req_data = 0
- busy = 0, done = 0, timeout = 0
- pkts_sent = 0, pkts_received = 0
- max_latency = 0, lat_sum = 0
- cycle counter = 0, LFSR = 0x0001
REQ-018 resp_ready SHALL be 0 while rst_n is low.

Configuration
REQ-019 With NEBULA_TG_LATENCY_EN defined:
- each received flit's latency SHALL be computed as (cycle − data[TS_W-1:0]) mod 2^TS_W;
- max_latency SHALL hold the running maximum;
- lat_sum SHALL accumulate latencies and saturate.
REQ-020 Without NEBULA_TG_LATENCY_EN: max_latency and lat_sum SHALL be tied to 0, and no timestamp logic SHALL be synthesised.

Structure
REQ-021 tg_pattern_t (2-bit enum) and tg_state_t SHALL be added to nebula_pkg. flit_t and PACKET_DATA SHALL come from nebula_pkg.
REQ-022 The LFSR SHALL be a sub-module nebula_lfsr with ports clk, rst_n, load, seed, en, value.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- NN, MY=(3,1), 4x4, num=5, rate=15, req_ready=1 → 5 flits on consecutive cycles, dest (0,1), seq 0..4, pkts_sent=5, state DRAIN.
- req_ready held 0 for 10 cycles mid-run → req_valid stays 1, req_data unchanged, pkts_sent constant.
- TRANSPOSE, MY=(1,3) → dest (3,1). HOTSPOT (2,2) → all flits dest (2,2).
- Latency enabled: bench echoes each flit on resp 7 cycles after its handshake → max_latency=7, lat_sum=7×num, done with timeout=0.
- No responses, DRAIN_TIMEOUT=64 → done=1, timeout=1, exactly 64 cycles after entering DRAIN.
- rst_n low mid-RUN with req_valid=1 → req_valid=0 and counters 0 before the next clk edge; start after release → run restarts from seq 0.
